regfile_param: RTL and testbench
================================

Name: regfile_param

Overview:
- Parametrised successor to the 32x64 CPU register file, used by the datapath for operand fetch and result writeback.
- Generalised in data width, depth and read-port count; the hardwired zero register is configurable.
- Adds a second write port, optional same-cycle write-to-read bypass, and a per-register busy scoreboard so a pipelined core can track in-flight producers.

Parameters:
- DATA_W, 64, register width in bits.
- NUM_REGS, 32, number of architectural registers (2..64).
- ADDR_W, 5, address width; must satisfy 2**ADDR_W >= NUM_REGS.
- NUM_RD, 2, number of independent read ports (1..4).
- ZERO_REG, 31, index hardwired to zero; -1 disables the zero register.
- BYPASS, 1, 1 = reads see same-cycle write data; 0 = reads see stored value only.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port p uses slice p.
- rd_data  out  NUM_RD*DATA_W  read data; port p uses slice p.
- rd_busy  out  NUM_RD  busy flag of the addressed register.
- wr_en  in  2  write enables for write ports 0 and 1.
- wr_addr  in  2*ADDR_W  write addresses.
- wr_data  in  2*DATA_W  write data.
- claim_en  in  1  marks a register busy (new producer issued).
- claim_addr  in  ADDR_W  register being claimed.

Behaviour:
- Interface fixed: one clock (clk); reset is asynchronous and active-low (reset_n).
- Reset: all registers clear to 0 and all busy bits clear to 0 immediately on reset_n low, independent of clk. Outputs are combinational from that state, so rd_data = 0 and rd_busy = 0 during reset.
- Storage updates on the clk rising edge only. Read path is combinational, latency 0.
- Write: when wr_en[k]=1 and wr_addr[k] is valid, the register takes wr_data[k] at the edge.
- A write address is invalid if it is >= NUM_REGS or equals ZERO_REG; such writes are ignored.
- Both write ports targeting the same address in one cycle: port 1 wins; port 0's data is discarded.
- Read: rd_data[p] returns the stored register.
  - Addresses >= NUM_REGS or equal to ZERO_REG return 0, and rd_busy[p] = 0.
- Bypass (BYPASS=1): if any valid write matches rd_addr[p] in the same cycle, rd_data[p] returns that write's data (port 1 first). rd_busy[p] then reads 0 unless a claim to the same address is also active that cycle.
- Bypass (BYPASS=0): reads show the pre-edge value and the registered busy bit.
- Scoreboard:
  - The busy bit sets at the edge on claim_en with a valid claim_addr.
  - It clears at the edge when any valid write targets that register.
  - Claim and write to the same register in the same cycle: busy stays set (claim wins; the write data is still stored).
  - Claims to ZERO_REG or out-of-range addresses are ignored.
- Bit widths are exact; no sign or zero extension is performed.
- Reset asserted mid-operation: pending writes and claims in that cycle are lost, and state is zero once reset is released.

Decomposition:
- regfile_pkg holds:
  - localparam helpers: addr_valid(), which checks range and the zero register;
  - the RF_PORT1_PRIORITY constant;
  - typedefs: rf_word_t, rf_addr_t.
- One sub-module, regfile_read_port:
  - NUM_REGS:1 read mux plus bypass/busy selection;
  - instantiated NUM_RD times in a generate loop.
- Storage and scoreboard stay in the top module, as an always_ff with async reset on negedge reset_n.

Test Plan:
- Reset check: pulse reset_n low between edges, then read all addresses -> rd_data=0 and rd_busy=0 everywhere, with the async clear visible before the next edge.
- Pattern sweep: write i*64'h0000010204080001 to regs 0..30 on port 0, then read all 32 on both ports -> stored pattern returned; reg 31 reads 0 even after a prior write of 64'hA0.
- Write collision: wr_en=2'b11, both addresses 5, data 64'h1111 / 64'h2222 -> reg 5 reads 64'h2222 next cycle.
- Bypass: BYPASS=1, write 64'hDEAD to reg 7 while reading reg 7 -> rd_data=64'hDEAD the same cycle. With BYPASS=0 -> old value that cycle and 64'hDEAD after the edge.
- Scoreboard:
  - claim reg 3 -> rd_busy=1 next cycle;
  - write reg 3 -> rd_busy=0 after the edge;
  - claim plus write to reg 3 in the same cycle -> busy stays 1 and the data is updated.
- Parameter variant: NUM_REGS=24, ZERO_REG=-1, NUM_RD=3 -> reg 31 is writable as reg 23; address 30 reads 0 and its writes are ignored; all three read ports are independent.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types, constants and address check for the parametrised register file
package regfile_pkg;

    localparam int RF_DEFAULT_DATA_W = 64;
    localparam int RF_DEFAULT_ADDR_W = 5;

    // When both write ports hit one register, port 1 is the younger result and wins
    localparam bit RF_PORT1_PRIORITY = 1'b1;

    typedef logic [RF_DEFAULT_DATA_W-1:0] rf_word_t;
    typedef logic [RF_DEFAULT_ADDR_W-1:0] rf_addr_t;

    // A negative zero_reg never matches, which disables the hardwired zero register
    function automatic logic addr_valid(input logic [31:0] addr, input int num_regs, input int zero_reg);
        return (addr < $unsigned(num_regs)) && (int'(addr) != zero_reg);
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - one combinational read port: register mux, write bypass and busy select
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31,
    parameter int BYPASS   = 1
) (
    input  logic [ADDR_W-1:0]          i_rd_addr,
    input  logic [NUM_REGS*DATA_W-1:0] i_regs,
    input  logic [NUM_REGS-1:0]        i_busy,
    input  logic [1:0]                 i_wr_ok,
    input  logic [2*ADDR_W-1:0]        i_wr_addr,
    input  logic [2*DATA_W-1:0]        i_wr_data,
    input  logic                       i_claim_ok,
    input  logic [ADDR_W-1:0]          i_claim_addr,
    output logic [DATA_W-1:0]          o_rd_data,
    output logic                       o_rd_busy
);

    localparam int HI = RF_PORT1_PRIORITY ? 1 : 0;
    localparam int LO = 1 - HI;

    logic              w_addr_ok;
    logic              w_hit_hi;
    logic              w_hit_lo;
    logic              w_claim_hit;
    logic [DATA_W-1:0] w_stored;
    logic              w_stored_busy;

    assign w_addr_ok   = addr_valid(32'(i_rd_addr), NUM_REGS, ZERO_REG);
    assign w_hit_hi    = i_wr_ok[HI] && (i_wr_addr[HI*ADDR_W +: ADDR_W] == i_rd_addr);
    assign w_hit_lo    = i_wr_ok[LO] && (i_wr_addr[LO*ADDR_W +: ADDR_W] == i_rd_addr);
    assign w_claim_hit = i_claim_ok && (i_claim_addr == i_rd_addr);

    always_comb begin
        w_stored      = '0;
        w_stored_busy = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i_rd_addr == ADDR_W'(i)) begin
                w_stored      = i_regs[i*DATA_W +: DATA_W];
                w_stored_busy = i_busy[i];
            end
        end
    end

    // A bypassed result is already produced, so busy only survives a same-cycle re-claim
    always_comb begin
        o_rd_data = w_stored;
        o_rd_busy = w_stored_busy;
        if ((BYPASS != 0) && (w_hit_hi || w_hit_lo)) begin
            o_rd_data = w_hit_hi ? i_wr_data[HI*DATA_W +: DATA_W] : i_wr_data[LO*DATA_W +: DATA_W];
            o_rd_busy = w_claim_hit;
        end
        if (!w_addr_ok) begin
            o_rd_data = '0;
            o_rd_busy = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parametrised register file with two write ports, bypass and busy scoreboard
module regfile_param
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 31,
    parameter int BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic [1:0]                 wr_en,
    input  logic [2*ADDR_W-1:0]        wr_addr,
    input  logic [2*DATA_W-1:0]        wr_data,
    input  logic                       claim_en,
    input  logic [ADDR_W-1:0]          claim_addr
);

    logic [DATA_W-1:0]          r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]        r_busy;

    logic [NUM_REGS*DATA_W-1:0] w_regs_flat;
    logic [ADDR_W-1:0]          w_wr_addr0;
    logic [ADDR_W-1:0]          w_wr_addr1;
    logic [DATA_W-1:0]          w_wr_data0;
    logic [DATA_W-1:0]          w_wr_data1;
    logic [1:0]                 w_wr_ok;
    logic [1:0]                 w_wr_win;
    logic                       w_same_addr;
    logic                       w_claim_ok;

    assign w_wr_addr0 = wr_addr[0 +: ADDR_W];
    assign w_wr_addr1 = wr_addr[ADDR_W +: ADDR_W];
    assign w_wr_data0 = wr_data[0 +: DATA_W];
    assign w_wr_data1 = wr_data[DATA_W +: DATA_W];

    // Qualifying with reset_n keeps bypass and claims silent while reset is held
    assign w_wr_ok[0]  = reset_n && wr_en[0] && addr_valid(32'(w_wr_addr0), NUM_REGS, ZERO_REG);
    assign w_wr_ok[1]  = reset_n && wr_en[1] && addr_valid(32'(w_wr_addr1), NUM_REGS, ZERO_REG);
    assign w_claim_ok  = reset_n && claim_en && addr_valid(32'(claim_addr), NUM_REGS, ZERO_REG);
    assign w_same_addr = (w_wr_addr0 == w_wr_addr1);

    assign w_wr_win[0] = w_wr_ok[0] && !(w_wr_ok[1] && w_same_addr && RF_PORT1_PRIORITY);
    assign w_wr_win[1] = w_wr_ok[1] && !(w_wr_ok[0] && w_same_addr && !RF_PORT1_PRIORITY);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_wr_win[1] && (w_wr_addr1 == ADDR_W'(i))) begin
                    r_regs[i] <= w_wr_data1;
                end else if (w_wr_win[0] && (w_wr_addr0 == ADDR_W'(i))) begin
                    r_regs[i] <= w_wr_data0;
                end
                // A new producer issued in the same cycle outlives the retiring one
                if (w_claim_ok && (claim_addr == ADDR_W'(i))) begin
                    r_busy[i] <= 1'b1;
                end else if ((w_wr_ok[0] && (w_wr_addr0 == ADDR_W'(i))) ||
                             (w_wr_ok[1] && (w_wr_addr1 == ADDR_W'(i)))) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_flat
            assign w_regs_flat[g*DATA_W +: DATA_W] = r_regs[g];
        end

        for (g = 0; g < NUM_RD; g++) begin : g_rd
            regfile_read_port #(
                .DATA_W   (DATA_W),
                .NUM_REGS (NUM_REGS),
                .ADDR_W   (ADDR_W),
                .ZERO_REG (ZERO_REG),
                .BYPASS   (BYPASS)
            ) u_rd (
                .i_rd_addr    (rd_addr[g*ADDR_W +: ADDR_W]),
                .i_regs       (w_regs_flat),
                .i_busy       (r_busy),
                .i_wr_ok      (w_wr_ok),
                .i_wr_addr    (wr_addr),
                .i_wr_data    (wr_data),
                .i_claim_ok   (w_claim_ok),
                .i_claim_addr (claim_addr),
                .o_rd_data    (rd_data[g*DATA_W +: DATA_W]),
                .o_rd_busy    (rd_busy[g])
            );
        end
    endgenerate

endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - scoreboard bench for regfile_param in default, no-bypass and 24-reg variants
module tb_regfile_param;

    typedef struct packed {
        logic [31:0] cyc;
        logic [1:0]  dut;
        logic [1:0]  port;
        logic [63:0] data;
        logic        busy;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    exp_t  exp_q[$];
    string name_q[$];

    // dut 0: defaults; dut 1: BYPASS=0; dut 2: 24 regs, no zero reg, 3 read ports
    logic [9:0]   a_rd_addr = '0, b_rd_addr = '0;
    logic [14:0]  c_rd_addr = '0;
    logic [127:0] a_rd_data, b_rd_data;
    logic [191:0] c_rd_data;
    logic [1:0]   a_rd_busy, b_rd_busy;
    logic [2:0]   c_rd_busy;
    logic [1:0]   a_wr_en = '0, b_wr_en = '0, c_wr_en = '0;
    logic [9:0]   a_wr_addr = '0, b_wr_addr = '0, c_wr_addr = '0;
    logic [127:0] a_wr_data = '0, b_wr_data = '0, c_wr_data = '0;
    logic         a_claim_en = 1'b0, b_claim_en = 1'b0, c_claim_en = 1'b0;
    logic [4:0]   a_claim_addr = '0, b_claim_addr = '0, c_claim_addr = '0;

    regfile_param u_a (
        .clk(clk), .reset_n(reset_n), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .claim_en(a_claim_en), .claim_addr(a_claim_addr)
    );

    regfile_param #(.BYPASS(0)) u_b (
        .clk(clk), .reset_n(reset_n), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .claim_en(b_claim_en), .claim_addr(b_claim_addr)
    );

    regfile_param #(.NUM_REGS(24), .ZERO_REG(-1), .NUM_RD(3)) u_c (
        .clk(clk), .reset_n(reset_n), .rd_addr(c_rd_addr), .rd_data(c_rd_data), .rd_busy(c_rd_busy),
        .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data),
        .claim_en(c_claim_en), .claim_addr(c_claim_addr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] pat(input int i);
        return 64'(i) * 64'h0000010204080001;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        a_wr_en = '0; b_wr_en = '0; c_wr_en = '0;
        a_claim_en = 1'b0; b_claim_en = 1'b0; c_claim_en = 1'b0;
    endtask

    task automatic wr(input int d, input int k, input int addr, input logic [63:0] data);
        case (d)
            0: begin a_wr_en[k] = 1'b1; a_wr_addr[k*5 +: 5] = 5'(addr); a_wr_data[k*64 +: 64] = data; end
            1: begin b_wr_en[k] = 1'b1; b_wr_addr[k*5 +: 5] = 5'(addr); b_wr_data[k*64 +: 64] = data; end
            default: begin c_wr_en[k] = 1'b1; c_wr_addr[k*5 +: 5] = 5'(addr); c_wr_data[k*64 +: 64] = data; end
        endcase
    endtask

    task automatic claim(input int d, input int addr);
        case (d)
            0: begin a_claim_en = 1'b1; a_claim_addr = 5'(addr); end
            1: begin b_claim_en = 1'b1; b_claim_addr = 5'(addr); end
            default: begin c_claim_en = 1'b1; c_claim_addr = 5'(addr); end
        endcase
    endtask

    task automatic rdx(input int d, input int p, input int addr, input logic [63:0] data,
                       input logic busy, input string nm);
        exp_t e;
        case (d)
            0: a_rd_addr[p*5 +: 5] = 5'(addr);
            1: b_rd_addr[p*5 +: 5] = 5'(addr);
            default: c_rd_addr[p*5 +: 5] = 5'(addr);
        endcase
        e.cyc  = 32'(cyc);
        e.dut  = 2'(d);
        e.port = 2'(p);
        e.data = data;
        e.busy = busy;
        exp_q.push_back(e);
        name_q.push_back($sformatf("%s@%0d", nm, addr));
    endtask

    task automatic get_act(input int d, input int p, output logic [63:0] dat, output logic bsy);
        case (d)
            0: begin dat = a_rd_data[p*64 +: 64]; bsy = a_rd_busy[p]; end
            1: begin dat = b_rd_data[p*64 +: 64]; bsy = b_rd_busy[p]; end
            default: begin dat = c_rd_data[p*64 +: 64]; bsy = c_rd_busy[p]; end
        endcase
    endtask

    // Monitor: compares queued expectations against outputs at the falling edge of their cycle
    initial begin
        exp_t        e;
        string       nm;
        logic [63:0] dat;
        logic        bsy;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc <= 32'(cyc)) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                get_act(int'(e.dut), int'(e.port), dat, bsy);
                total++;
                if (dat !== e.data || bsy !== e.busy) begin
                    bad++;
                    $display("FAIL %s dut%0d port%0d: got data=%h busy=%b, want data=%h busy=%b",
                             nm, e.dut, e.port, dat, bsy, e.data, e.busy);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        rdx(0, 0, 0, 64'h0, 1'b0, "reset_a");
        rdx(2, 2, 23, 64'h0, 1'b0, "reset_c");
        step();
        reset_n = 1'b1;

        // Pattern sweep on the default instance, reg 31 written first but hardwired to zero
        step();
        wr(0, 0, 31, 64'hA0);
        for (int i = 0; i < 31; i++) begin
            step();
            wr(0, 0, i, pat(i));
        end
        for (int j = 0; j < 16; j++) begin
            step();
            rdx(0, 0, 2*j,   (2*j < 31)   ? pat(2*j)   : 64'h0, 1'b0, "sweep");
            rdx(0, 1, 2*j+1, (2*j+1 < 31) ? pat(2*j+1) : 64'h0, 1'b0, "sweep");
        end

        step();
        wr(0, 0, 5, 64'h1111);
        wr(0, 1, 5, 64'h2222);
        rdx(0, 0, 5, 64'h2222, 1'b0, "coll_byp");
        step();
        rdx(0, 0, 5, 64'h2222, 1'b0, "coll");

        step();
        wr(0, 0, 7, 64'hDEAD);
        rdx(0, 1, 7, 64'hDEAD, 1'b0, "byp_a");
        rdx(0, 0, 8, pat(8), 1'b0, "byp_other");

        step();
        wr(1, 0, 7, 64'h77);
        step();
        wr(1, 0, 7, 64'hDEAD);
        rdx(1, 0, 7, 64'h77, 1'b0, "nobyp_old");
        step();
        rdx(1, 0, 7, 64'hDEAD, 1'b0, "nobyp_new");
        step();
        claim(1, 3);
        wr(1, 1, 3, 64'h5);
        rdx(1, 0, 3, 64'h0, 1'b0, "nobyp_claim");
        step();
        rdx(1, 0, 3, 64'h5, 1'b1, "nobyp_busy");

        step();
        claim(0, 3);
        rdx(0, 0, 3, pat(3), 1'b0, "pre_claim");
        step();
        rdx(0, 0, 3, pat(3), 1'b1, "claimed");
        step();
        wr(0, 1, 3, 64'h33);
        rdx(0, 0, 3, 64'h33, 1'b0, "byp_clr");
        step();
        rdx(0, 0, 3, 64'h33, 1'b0, "cleared");
        step();
        claim(0, 3);
        wr(0, 0, 3, 64'h44);
        rdx(0, 0, 3, 64'h44, 1'b1, "byp_claim");
        step();
        rdx(0, 0, 3, 64'h44, 1'b1, "claim_wins");
        step();
        claim(0, 31);
        rdx(0, 1, 31, 64'h0, 1'b0, "zero_claim_now");
        step();
        rdx(0, 1, 31, 64'h0, 1'b0, "zero_claim");

        // Reset pulse between edges with a write pending; clear must show before the next edge
        step();
        reset_n = 1'b0;
        wr(0, 0, 10, 64'h55);
        rdx(0, 0, 3, 64'h0, 1'b0, "rst_async");
        rdx(0, 1, 7, 64'h0, 1'b0, "rst_async");
        rdx(1, 0, 3, 64'h0, 1'b0, "rst_async_b");
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        a_wr_en = '0;
        for (int j = 0; j < 16; j++) begin
            step();
            rdx(0, 0, 2*j,   64'h0, 1'b0, "rst_sweep");
            rdx(0, 1, 2*j+1, 64'h0, 1'b0, "rst_sweep");
        end

        step();
        wr(2, 0, 23, 64'hC23);
        wr(2, 1, 0, 64'hC00);
        step();
        wr(2, 0, 30, 64'hBAD);
        rdx(2, 0, 30, 64'h0, 1'b0, "c_inv_byp");
        rdx(2, 1, 23, 64'hC23, 1'b0, "c_r23");
        rdx(2, 2, 0, 64'hC00, 1'b0, "c_r0");
        step();
        claim(2, 30);
        rdx(2, 0, 30, 64'h0, 1'b0, "c_inv_wr");
        rdx(2, 1, 0, 64'hC00, 1'b0, "c_indep");
        rdx(2, 2, 23, 64'hC23, 1'b0, "c_indep");
        step();
        claim(2, 23);
        rdx(2, 0, 30, 64'h0, 1'b0, "c_inv_claim");
        step();
        rdx(2, 0, 23, 64'hC23, 1'b1, "c_busy");
        rdx(2, 1, 31, 64'h0, 1'b0, "c_oob");
        rdx(2, 2, 22, 64'h0, 1'b0, "c_r22");

        step();
        step();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
